// File: rtl/key_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen_pkg
// Description : Shared definitions for the key conditioning block:
//               - FSM state encodings (IDLE..RELEASE_WAIT)
//               - default timing constants
//               - synchroniser reset level (key released)
//               - registered output bundle type
// Revision    : 1.0 - initial release
// ============================================================================
package key_pulse_gen_pkg;

    // Default timing constants, used as parameter defaults by the top level
    localparam int unsigned KEY_CNT_W_DEF          = 24;
    localparam int unsigned KEY_DEBOUNCE_DEF       = 4;
    localparam int unsigned KEY_REPEAT_DELAY_DEF   = 10;
    localparam int unsigned KEY_REPEAT_PERIOD_DEF  = 5;

    // FSM state encoding
    localparam int unsigned KEY_ST_W = 3;
    localparam logic [KEY_ST_W-1:0] ST_IDLE         = 3'd0;
    localparam logic [KEY_ST_W-1:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [KEY_ST_W-1:0] ST_HELD         = 3'd2;
    localparam logic [KEY_ST_W-1:0] ST_REPEAT       = 3'd3;
    localparam logic [KEY_ST_W-1:0] ST_RELEASE_WAIT = 3'd4;

    // Raw key is active-low, so the synchroniser resets to "released"
    localparam logic SYNC_RST_VAL = 1'b1;

    // Registered output bundle
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic step;
    } key_out_t;

endpackage
`default_nettype wire

// File: rtl/key_pulse_gen_sync.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen_sync
// Description : Two-flop synchroniser for the raw, asynchronous key input.
//               Both flops reset to the released level so a key held across
//               reset deassertion is seen as a fresh press.
// Ports       : clk      in  system clock
//               lo_rst   in  asynchronous active-high reset
//               async_i  in  raw asynchronous input
//               sync_o   out synchronised copy of async_i (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module key_pulse_gen_sync
    import key_pulse_gen_pkg::*;
(
    input  logic clk,
    input  logic lo_rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge lo_rst) begin
        if (lo_rst) begin
            meta_q <= SYNC_RST_VAL;
            sync_q <= SYNC_RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen
// Description : Turns one raw active-low push-button into clean single-cycle
//               control pulses: synchronise, debounce, press/release edge
//               detect and optional hold-to-auto-repeat.
// Ports       : clk              in  system clock (rising edge)
//               lo_rst           in  asynchronous active-high reset
//               key_n_i          in  raw button, 0 = pressed, asynchronous
//               rpt_en_i         in  auto-repeat enable
//               key_level_o      out debounced key state, 1 = pressed
//               press_pulse_o    out one-cycle pulse on accepted press
//               release_pulse_o  out one-cycle pulse on accepted release
//               step_pulse_o     out press pulse OR auto-repeat pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W           = KEY_CNT_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
    parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic lo_rst,
    input  logic key_n_i,
    input  logic rpt_en_i,
    output logic key_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic step_pulse_o
);

    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_limit = CNT_W'(DEBOUNCE_CYCLES);
    // Timers count from 0, so a step fires when the timer reaches N-1
    localparam logic [CNT_W-1:0] c_delay_m1  =
        CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_period_m1 =
        CNT_W'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
    localparam logic c_rpt_on = (REPEAT_DELAY != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_one;
    endfunction

    logic                 key_raw_sync;
    logic                 key_sync;
    logic [KEY_ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0]     deb_q, deb_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    key_out_t             out_q, out_d;

    key_pulse_gen_sync u_sync (
        .clk     (clk),
        .lo_rst  (lo_rst),
        .async_i (key_n_i),
        .sync_o  (key_raw_sync)
    );

    // Active-high pressed indication
    assign key_sync = ~key_raw_sync;

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        out_d       = '0;
        out_d.level = out_q.level;

        case (state_q)
            ST_IDLE: begin
                if (key_sync) begin
                    state_d = ST_PRESS_WAIT;
                    deb_d   = c_one;
                end
            end

            ST_PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (deb_q >= c_deb_limit) begin
                    state_d     = ST_HELD;
                    deb_d       = '0;
                    hold_d      = '0;
                    out_d.level = 1'b1;
                    out_d.press = 1'b1;
                    out_d.step  = 1'b1;
                end else begin
                    deb_d = sat_inc(deb_q);
                end
            end

            ST_HELD: begin
                if (!key_sync) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = c_one;
                end else if (c_rpt_on && rpt_en_i && (hold_q >= c_delay_m1)) begin
                    // >= so a late rpt_en after a long hold repeats at once
                    state_d    = ST_REPEAT;
                    hold_d     = '0;
                    out_d.step = 1'b1;
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end

            ST_REPEAT: begin
                if (!key_sync) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = c_one;
                    hold_d  = '0;
                end else if (!rpt_en_i) begin
                    state_d = ST_HELD;
                    hold_d  = '0;
                end else if (hold_q >= c_period_m1) begin
                    hold_d     = '0;
                    out_d.step = 1'b1;
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end

            ST_RELEASE_WAIT: begin
                if (key_sync) begin
                    // Release glitch: back to held, restart the repeat delay
                    state_d = ST_HELD;
                    deb_d   = '0;
                    hold_d  = '0;
                end else if (deb_q >= c_deb_limit) begin
                    state_d     = ST_IDLE;
                    deb_d       = '0;
                    out_d.level = 1'b0;
                    out_d.rel   = 1'b1;
                end else begin
                    deb_d = sat_inc(deb_q);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                deb_d       = '0;
                hold_d      = '0;
                out_d.level = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge lo_rst) begin
        if (lo_rst) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

    assign key_level_o     = out_q.level;
    assign press_pulse_o   = out_q.press;
    assign release_pulse_o = out_q.rel;
    assign step_pulse_o    = out_q.step;

endmodule
`default_nettype wire
